// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, writeback request type and grant source encoding
package cpu_pkg;
  localparam int REG_ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 8'd255;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_MEM, SRC_FPU} src_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of writeback requests; count is one bit wider than the pointers
module wb_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  wb_req_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr] <= push_req;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU, load and FPU results onto the register-file write port
module writeback_arbiter import cpu_pkg::*; #(
  parameter int FIFO_DEPTH = 2,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  fpu_valid,
  output logic                  fpu_ready,
  input  logic [REG_ADDR_W-1:0] fpu_dest,
  input  logic [DATA_W-1:0]     fpu_data,
  output logic                  wb_enable,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_pending
);
  wb_req_t mem_head, fpu_head, win;
  logic mem_full, mem_empty, fpu_full, fpu_empty, prefer_mem;
  src_t grant;
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clock(clock), .reset(reset), .push(mem_valid), .push_req(wb_req_t'{mem_dest, mem_data}),
    .pop(grant == SRC_MEM), .head(mem_head), .full(mem_full), .empty(mem_empty)
  );
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fpu_fifo (
    .clock(clock), .reset(reset), .push(fpu_valid), .push_req(wb_req_t'{fpu_dest, fpu_data}),
    .pop(grant == SRC_FPU), .head(fpu_head), .full(fpu_full), .empty(fpu_empty)
  );
  assign mem_ready = !mem_full;
  assign fpu_ready = !fpu_full;
  assign wb_pending = !mem_empty || !fpu_empty;
  // ALU cannot stall, so it always wins; load/FPU share the remaining slots round-robin
  always_comb grant = alu_valid ? SRC_ALU :
                      (!mem_empty && (fpu_empty || prefer_mem)) ? SRC_MEM :
                      !fpu_empty ? SRC_FPU : SRC_NONE;
  always_comb win = grant == SRC_MEM ? mem_head :
                    grant == SRC_FPU ? fpu_head : wb_req_t'{alu_dest, alu_data};
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_enable <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
      prefer_mem <= 1'b1;
    end else begin
      wb_enable <= grant != SRC_NONE && win.dest != ZERO_REG;
      if (grant != SRC_NONE) begin
        wb_dest <= win.dest;
        wb_data <= win.data;
      end
      if (grant == SRC_MEM || grant == SRC_FPU) prefer_mem <= grant == SRC_FPU;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed stimulus checked against a queue-based writeback model
module tb_writeback_arbiter;
  localparam int DEPTH = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic alu_valid, mem_valid, fpu_valid;
  logic [7:0] alu_dest, mem_dest, fpu_dest;
  logic [31:0] alu_data, mem_data, fpu_data;
  logic mem_ready, fpu_ready, wb_enable, wb_pending;
  logic [7:0] wb_dest;
  logic [31:0] wb_data;
  int passed = 0, total = 0;
  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .ZERO_REG(8'd255)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_dest(fpu_dest), .fpu_data(fpu_data),
    .wb_enable(wb_enable), .wb_dest(wb_dest), .wb_data(wb_data), .wb_pending(wb_pending)
  );
  always #5 clock = ~clock;
  typedef struct {logic [7:0] d; logic [31:0] v;} ent_t;
  ent_t mq[$], fq[$];
  logic prefer_mem, exp_en;
  logic [7:0] exp_dest;
  logic [31:0] exp_data;
  bit live = 0;
  // Model: ALU wins outright; otherwise the older-favoured of the two queues, then push new offers
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      fq.delete();
      prefer_mem <= 1'b1;
      exp_en <= 1'b0;
      exp_dest <= '0;
      exp_data <= '0;
      live <= 1'b1;
    end else begin
      ent_t w;
      bit g, mr, fr;
      mr = mq.size() < DEPTH;
      fr = fq.size() < DEPTH;
      g = 1;
      if (alu_valid) w = '{alu_dest, alu_data};
      else if (mq.size() > 0 && (fq.size() == 0 || prefer_mem)) begin
        w = mq.pop_front();
        prefer_mem <= 1'b0;
      end else if (fq.size() > 0) begin
        w = fq.pop_front();
        prefer_mem <= 1'b1;
      end else g = 0;
      if (mem_valid && mr) mq.push_back('{mem_dest, mem_data});
      if (fpu_valid && fr) fq.push_back('{fpu_dest, fpu_data});
      exp_en <= g && w.d != 8'd255;
      if (g) begin
        exp_dest <= w.d;
        exp_data <= w.v;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask
  always @(negedge clock) begin
    if (live) begin
      chk("m_wb_enable", 32'(wb_enable), 32'(exp_en));
      chk("m_wb_dest", 32'(wb_dest), 32'(exp_dest));
      chk("m_wb_data", wb_data, exp_data);
      chk("m_mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH));
      chk("m_fpu_ready", 32'(fpu_ready), 32'(fq.size() < DEPTH));
      chk("m_wb_pending", 32'(wb_pending), 32'(mq.size() > 0 || fq.size() > 0));
    end
  end
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    alu_valid = 0; mem_valid = 0; fpu_valid = 0;
    alu_dest = 0; mem_dest = 0; fpu_dest = 0;
    alu_data = 0; mem_data = 0; fpu_data = 0;
  endtask
  initial begin
    int seq [4];
    idle();
    repeat (2) cyc();
    reset = 0;
    @(negedge clock);
    chk("rst_en", 32'(wb_enable), 0);
    chk("rst_dest", 32'(wb_dest), 0);
    chk("rst_data", wb_data, 0);
    chk("rst_mem_ready", 32'(mem_ready), 1);
    chk("rst_fpu_ready", 32'(fpu_ready), 1);
    chk("rst_pending", 32'(wb_pending), 0);
    alu_valid = 1; alu_dest = 5; alu_data = 32'hDEADBEEF;
    cyc(); idle();
    @(negedge clock);
    chk("alu_en", 32'(wb_enable), 1);
    chk("alu_dest", 32'(wb_dest), 5);
    chk("alu_data", wb_data, 32'hDEADBEEF);
    cyc();
    @(negedge clock);
    chk("alu_en_off", 32'(wb_enable), 0);
    chk("alu_dest_hold", 32'(wb_dest), 5);
    mem_valid = 1; mem_dest = 7; mem_data = 32'h11;
    fpu_valid = 1; fpu_dest = 9; fpu_data = 32'h22;
    cyc(); idle();
    @(negedge clock);
    chk("dual_n1_en", 32'(wb_enable), 0);
    chk("dual_n1_pend", 32'(wb_pending), 1);
    cyc();
    @(negedge clock);
    chk("dual_mem_en", 32'(wb_enable), 1);
    chk("dual_mem_dest", 32'(wb_dest), 7);
    chk("dual_mem_data", wb_data, 32'h11);
    chk("dual_mem_pend", 32'(wb_pending), 1);
    cyc();
    @(negedge clock);
    chk("dual_fpu_dest", 32'(wb_dest), 9);
    chk("dual_fpu_data", wb_data, 32'h22);
    chk("dual_fpu_pend", 32'(wb_pending), 0);
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1; alu_dest = 1; alu_data = 32'(i);
      mem_valid = 1; mem_dest = 8'(30 + i); mem_data = 32'h300 + 32'(i);
      fpu_valid = 1; fpu_dest = 8'(40 + i); fpu_data = 32'h400 + 32'(i);
      cyc();
    end
    idle();
    chk("rr_mem_full", 32'(mem_ready), 0);
    chk("rr_fpu_full", 32'(fpu_ready), 0);
    seq = '{30, 40, 31, 41};
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clock);
      chk("rr_dest", 32'(wb_dest), 32'(seq[i]));
    end
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_dest = 8'(i + 1); alu_data = 32'(i);
      mem_valid = i < 3; mem_dest = 8'(20 + i); mem_data = 32'h100 + 32'(i);
      if (i == 2) chk("bp_mem_ready", 32'(mem_ready), 0);
      cyc();
    end
    idle();
    @(negedge clock);
    chk("bp_alu_dest", 32'(wb_dest), 4);
    cyc();
    @(negedge clock);
    chk("bp_ld0_dest", 32'(wb_dest), 20);
    chk("bp_ld0_data", wb_data, 32'h100);
    cyc();
    @(negedge clock);
    chk("bp_ld1_dest", 32'(wb_dest), 21);
    chk("bp_ld1_en", 32'(wb_enable), 1);
    cyc();
    @(negedge clock);
    chk("bp_done_en", 32'(wb_enable), 0);
    alu_valid = 1; alu_dest = 255; alu_data = 1;
    mem_valid = 1; mem_dest = 255; mem_data = 2;
    fpu_valid = 1; fpu_dest = 255; fpu_data = 3;
    cyc(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("zr_en", 32'(wb_enable), 0);
      cyc();
    end
    @(negedge clock);
    chk("zr_pending", 32'(wb_pending), 0);
    chk("zr_mem_ready", 32'(mem_ready), 1);
    chk("zr_fpu_ready", 32'(fpu_ready), 1);
    alu_valid = 1; alu_dest = 3; alu_data = 32'h33;
    mem_valid = 1; mem_dest = 50; mem_data = 32'h55;
    fpu_valid = 1; fpu_dest = 60; fpu_data = 32'h66;
    cyc(); idle();
    mem_valid = 1; mem_dest = 51; mem_data = 32'h77;
    reset = 1;
    cyc(); idle();
    reset = 0;
    @(negedge clock);
    chk("mr_en", 32'(wb_enable), 0);
    chk("mr_pending", 32'(wb_pending), 0);
    chk("mr_mem_ready", 32'(mem_ready), 1);
    chk("mr_fpu_ready", 32'(fpu_ready), 1);
    chk("mr_dest", 32'(wb_dest), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clock);
      chk("mr_no_write", 32'(wb_enable), 0);
    end
    for (int i = 0; i < 60; i++) begin
      alu_valid = i % 4 == 3; alu_dest = 8'(i); alu_data = 32'(i * 3);
      mem_valid = i % 3 != 2; mem_dest = (i % 7 == 0) ? 8'd255 : 8'(100 + i); mem_data = 32'(i * 5);
      fpu_valid = i % 2 == 0; fpu_dest = 8'(150 + i % 50); fpu_data = 32'(i * 7);
      cyc();
    end
    idle();
    repeat (6) cyc();
    @(negedge clock);
    chk("soak_drained", 32'(wb_pending), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
